// File: rtl/data_mem_resp.sv
// rtl/data_mem_resp.sv - data-memory responder with byte/half/word access and fixed-latency stall
// Optional multi-cycle mode enabled by defining DMEM_WAIT_EN; otherwise single-cycle.
module data_mem_resp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [2:0]            funct3M,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  MemStallM,
    output logic                  MisalignM
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            lane;
    logic                  req;
    logic                  is_byte;
    logic                  is_half;
    logic                  is_word;
    logic                  misalign;
    logic [NB-1:0]         be;
    logic [DATA_WIDTH-1:0] wdata_lane;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [DATA_WIDTH-1:0] load_val;
    logic                  commit;
    logic                  unused_bits;

    assign word_idx = ALUResultM[ADDR_WIDTH+1:2];
    assign lane     = ALUResultM[1:0];
    assign req      = MemReadM | MemWriteM;

    // Reserved funct3 codes (011, 11x) fall through to word size.
    assign is_byte  = (funct3M[1:0] == 2'b00);
    assign is_half  = (funct3M[1:0] == 2'b01);
    assign is_word  = !is_byte && !is_half;
    assign misalign = (is_half && lane[0]) || (is_word && (lane != 2'b00));

    always_comb begin
        be         = '0;
        wdata_lane = WriteDataM;
        if (is_byte) begin
            be[lane]   = 1'b1;
            wdata_lane = {NB{WriteDataM[7:0]}};
        end else if (is_half) begin
            be[{lane[1], 1'b0} +: 2] = 2'b11;
            wdata_lane = {(NB/2){WriteDataM[15:0]}};
        end else begin
            be = '1;
        end
    end

    assign rd_word = mem[word_idx];
    assign rd_byte = rd_word[{lane, 3'b000} +: 8];
    assign rd_half = rd_word[{lane[1], 4'b0000} +: 16];

    // Simultaneous read+write is a store, so it yields zero data.
    always_comb begin
        load_val = '0;
        if (MemReadM && !MemWriteM && !misalign) begin
            if (is_byte)
                load_val = {{(DATA_WIDTH-8){~funct3M[2] & rd_byte[7]}}, rd_byte};
            else if (is_half)
                load_val = {{(DATA_WIDTH-16){~funct3M[2] & rd_half[15]}}, rd_half};
            else
                load_val = rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i])
                    mem[word_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
            end
        end
    end

`ifdef DMEM_WAIT_EN
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam int            CW       = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 1) ? LATENCY - 2 : 0);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic          mis_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ReadDataM <= '0;
            mis_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE)
                cnt_q <= CNT_INIT;
            else if (state_q == S_WAIT && cnt_q != '0)
                cnt_q <= cnt_q - 1'b1;
            // Inputs are held stable by the hazard unit, so capture once on DONE entry.
            if (state_d == S_DONE) begin
                ReadDataM <= load_val;
                mis_q     <= misalign;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req) state_d = (LATENCY == 1) ? S_DONE : S_WAIT;
            S_WAIT:  if (cnt_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        MemStallM = ((state_q == S_IDLE) && req) || (state_q == S_WAIT);
        MisalignM = (state_q == S_DONE) && mis_q;
    end

    assign commit      = (state_q == S_DONE) && MemWriteM && !misalign && !reset;
    assign unused_bits = ^ALUResultM[DATA_WIDTH-1:ADDR_WIDTH+2];
`else
    always_comb begin
        ReadDataM = load_val;
        MisalignM = req && misalign;
        MemStallM = 1'b0;
    end

    assign commit      = MemWriteM && !misalign && !reset;
    assign unused_bits = ^{ALUResultM[DATA_WIDTH-1:ADDR_WIDTH+2], (LATENCY > 0)};
`endif

endmodule
